// File: rtl/ex_divider_if.sv
// Request/result bundle between the issuing stage (master) and the divider (slave).
interface ex_divider_if;
    logic        div_valid;
    logic        div_ready;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;

    modport master (
        output div_valid, div_signed, dividend, divisor, flush, res_ready,
        input  div_ready, res_valid, quotient, remainder, busy
    );

    modport slave (
        input  div_valid, div_signed, dividend, divisor, flush, res_ready,
        output div_ready, res_valid, quotient, remainder, busy
    );
endinterface

// File: rtl/ex_divider.sv
// 32-bit signed/unsigned restoring divider, one quotient bit per cycle.
//   state | meaning
//   IDLE  | ready for a request
//   CALC  | 32 shift-subtract iterations on operand magnitudes
//   DONE  | result held until res_ready
module ex_divider (
    input  logic        clk,
    input  logic        reset,
    ex_divider_if.slave dif
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] q_out_q, q_out_d;
    logic [31:0] r_out_q, r_out_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        dz_q, dz_d;

    logic [33:0] diff;
    logic [32:0] rem_next;
    logic [31:0] quo_next;
    logic        accept;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    assign dif.div_ready = (state_q == IDLE);
    assign dif.busy      = (state_q != IDLE);
    assign dif.res_valid = (state_q == DONE);
    assign dif.quotient  = q_out_q;
    assign dif.remainder = r_out_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        q_out_d   = q_out_q;
        r_out_d   = r_out_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;

        // 34-bit difference so a borrow is visible even when the shifted remainder exceeds 2^32
        diff     = {rem_q, quo_q[31]} - {2'b00, dvs_q};
        rem_next = diff[33] ? {rem_q[31:0], quo_q[31]} : diff[32:0];
        quo_next = {quo_q[30:0], ~diff[33]};
        accept   = dif.div_valid && (state_q == IDLE) && !dif.flush;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = CALC;
                    cnt_d     = 5'd0;
                    rem_d     = 33'd0;
                    quo_d     = (dif.div_signed && dif.dividend[31]) ? neg32(dif.dividend) : dif.dividend;
                    dvs_d     = (dif.div_signed && dif.divisor[31])  ? neg32(dif.divisor)  : dif.divisor;
                    neg_quo_d = dif.div_signed && (dif.dividend[31] ^ dif.divisor[31]);
                    neg_rem_d = dif.div_signed && dif.dividend[31];
                    dz_d      = (dif.divisor == 32'd0);
                end
            end
            CALC: begin
                rem_d = rem_next;
                quo_d = quo_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DONE;
                    // divide-by-zero keeps the all-ones quotient; remainder correction restores the dividend
                    q_out_d = (neg_quo_q && !dz_q) ? neg32(quo_next) : quo_next;
                    r_out_d = neg_rem_q ? neg32(rem_next[31:0]) : rem_next[31:0];
                end
            end
            DONE: begin
                if (dif.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (dif.flush) begin
            state_d = IDLE;
            q_out_d = q_out_q;
            r_out_d = r_out_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            rem_q     <= 33'd0;
            quo_q     <= 32'd0;
            dvs_q     <= 32'd0;
            q_out_q   <= 32'd0;
            r_out_q   <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            q_out_q   <= q_out_d;
            r_out_q   <= r_out_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
        end
    end
endmodule

// File: tb/tb_ex_divider.sv
// Scoreboard bench for ex_divider: driver pushes expected results, monitor pops on handshake.
module tb_ex_divider;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;
    exp_t sb[$];

    ex_divider_if dif();

    ex_divider dut (
        .clk   (clk),
        .reset (reset),
        .dif   (dif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares on every result handshake
    always @(negedge clk) begin
        if (!reset && dif.res_valid && dif.res_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got q=%h r=%h with no request outstanding",
                         dif.quotient, dif.remainder);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", dif.quotient, e.q);
                check("remainder", dif.remainder, e.r);
            end
        end
    end

    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input int hold);
        int lat;
        logic busy_ok;
        logic [31:0] q0, r0;
        check("ready_before_req", {31'd0, dif.div_ready}, 32'd1);
        dif.div_valid  = 1'b1;
        dif.div_signed = s;
        dif.dividend   = a;
        dif.divisor    = b;
        sb.push_back('{q: eq, r: er});
        step();
        dif.div_valid  = 1'b0;
        dif.div_signed = ~s;
        dif.dividend   = ~a;
        dif.divisor    = a ^ b ^ 32'h5A5A_A5A5;
        lat     = 1;
        busy_ok = 1'b1;
        while (!dif.res_valid && lat < 40) begin
            if (!dif.busy || dif.div_ready) busy_ok = 1'b0;
            step();
            lat++;
        end
        check("latency", lat, 33);
        check("busy_during_calc", {31'd0, busy_ok}, 32'd1);
        q0 = dif.quotient;
        r0 = dif.remainder;
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_valid", {31'd0, dif.res_valid}, 32'd1);
            check("hold_quotient", dif.quotient, q0);
            check("hold_remainder", dif.remainder, r0);
            check("hold_not_ready", {31'd0, dif.div_ready}, 32'd0);
        end
        dif.res_ready = 1'b1;
        check("handshake_not_ready", {31'd0, dif.div_ready}, 32'd0);
        step();
        dif.res_ready = 1'b0;
        check("idle_after_handshake", {30'd0, dif.div_ready, dif.busy}, 32'd2);
    endtask

    task automatic watch_no_result(input string name);
        logic seen;
        seen = 1'b0;
        dif.res_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (dif.res_valid) seen = 1'b1;
            step();
        end
        dif.res_ready = 1'b0;
        check(name, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        dif.div_valid  = 1'b0;
        dif.div_signed = 1'b0;
        dif.dividend   = 32'd0;
        dif.divisor    = 32'd0;
        dif.flush      = 1'b0;
        dif.res_ready  = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_ready_busy", {30'd0, dif.div_ready, dif.busy}, 32'd2);
        check("rst_res_valid", {31'd0, dif.res_valid}, 32'd0);
        check("rst_quotient", dif.quotient, 32'd0);
        check("rst_remainder", dif.remainder, 32'd0);

        do_div(1'b0, 32'd100,        32'd7,        32'd14,        32'd2,        0);
        do_div(1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        do_div(1'b0, 32'hFFFF_FFF9,  32'd2,        32'h7FFF_FFFC, 32'd1,        0);
        do_div(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,       0);
        do_div(1'b0, 32'h1234_5678,  32'd0,        32'hFFFF_FFFF, 32'h1234_5678, 0);
        do_div(1'b1, 32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFF9, 0);
        do_div(1'b1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,       0);
        // held result then an immediate back-to-back request
        do_div(1'b1, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2, 32'hFFFF_FFFE, 5);
        do_div(1'b0, 32'd1000,       32'd10,       32'd100,       32'd0,        0);

        // flush at counter 10 with div_valid high
        dif.div_valid = 1'b1;
        dif.div_signed = 1'b0;
        dif.dividend  = 32'd1000;
        dif.divisor   = 32'd3;
        step();
        dif.div_valid = 1'b0;
        repeat (10) step();
        dif.flush     = 1'b1;
        dif.div_valid = 1'b1;
        dif.dividend  = 32'd77;
        dif.divisor   = 32'd5;
        step();
        dif.flush     = 1'b0;
        dif.div_valid = 1'b0;
        check("flush_idle", {29'd0, dif.div_ready, dif.busy, dif.res_valid}, 32'd4);
        watch_no_result("flush_no_result");
        do_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0);

        // reset at counter 20
        dif.div_valid = 1'b1;
        dif.dividend  = 32'd12345;
        dif.divisor   = 32'd11;
        step();
        dif.div_valid = 1'b0;
        repeat (20) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_ready_busy", {29'd0, dif.div_ready, dif.busy, dif.res_valid}, 32'd4);
        check("rst_mid_quotient", dif.quotient, 32'd0);
        check("rst_mid_remainder", dif.remainder, 32'd0);
        watch_no_result("rst_no_stale_result");
        do_div(1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 0);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_divider.md
EX_DIVIDER -- requirements
Module: ex_divider

Interface
REQ-001 SHALL provide clk  input  1  rising-edge clock; the only clock.
REQ-002 SHALL provide reset  input  1  synchronous, active-high reset.
REQ-003 SHALL provide div_valid  input  1  request valid from the issuing stage.
REQ-004 SHALL provide div_ready  output  1  unit can accept a request this cycle.
REQ-005 SHALL provide div_signed  input  1  1 = signed (div), 0 = unsigned (divu).
REQ-006 SHALL provide dividend  input  32  rs operand.
REQ-007 SHALL provide divisor  input  32  rt operand.
REQ-008 SHALL provide flush  input  1  cancel any request in flight.
REQ-009 SHALL provide res_valid  output  1  quotient/remainder are valid.
REQ-010 SHALL provide res_ready  input  1  consumer takes the result (HI/LO write path).
REQ-011 SHALL provide quotient  output  32  result destined for LO.
REQ-012 SHALL provide remainder  output  32  result destined for HI.
REQ-013 SHALL provide busy  output  1  high in CALC or DONE.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE; div_ready = (state==IDLE).
REQ-015 SHALL accept a request on a rising edge where div_valid && div_ready && !flush && !reset; acceptance captures dividend, divisor and div_signed, then moves to CALC with iteration counter = 0.
REQ-016 SHALL ignore operand and div_signed changes after acceptance.
REQ-017 SHALL form magnitudes at acceptance: for signed requests, negative operands are two's-complement negated; for unsigned requests, operands are used as is.
REQ-018 SHALL perform one restoring shift-subtract quotient bit per CALC cycle, MSB first, using a 33-bit partial remainder; 32 CALC cycles total; counter 5 bits, 0..31.
REQ-019 SHALL transition CALC->DONE on the edge where counter==31, and apply sign correction on that same edge: quotient negated if sign(dividend)^sign(divisor) (signed only); remainder negated if sign(dividend) (signed only).
REQ-020 SHALL assert res_valid exactly 33 cycles after the acceptance cycle, i.e. acceptance edge + 32 CALC edges.
REQ-021 SHALL keep res_valid, quotient and remainder stable in DONE until the cycle in which res_ready is high; DONE->IDLE on that edge.
REQ-022 SHALL not accept a new request during the handshake cycle (div_ready low in DONE); the earliest next acceptance is the cycle after return to IDLE.
REQ-023 SHALL, when divisor==0, produce quotient=32'hFFFFFFFF and remainder=original dividend (unmodified bits), signed or unsigned, with the normal 33-cycle latency.
REQ-024 SHALL, for signed 0x80000000 / 0xFFFFFFFF, produce quotient=0x80000000 and remainder=0 with no special-case error.
REQ-025 SHALL, when flush is high in any state, go to IDLE on that edge, deassert res_valid, and discard the result; flush beats div_valid in the same cycle (no acceptance).
REQ-026 SHALL hold quotient/remainder at their last values outside DONE; consumers qualify them with res_valid only.

Reset
REQ-027 SHALL, when reset is high at an edge, force state=IDLE, counter=0, res_valid=0, quotient=0, remainder=0 and internal operand/remainder registers=0, overriding flush, div_valid and res_ready.
REQ-028 SHALL make div_ready=1 and busy=0 from the first cycle after reset; reset mid-CALC or in DONE aborts with no res_valid pulse.

Verification
REQ-029 SHALL cover: unsigned 100/7 -> quotient=14, remainder=2, res_valid rises 33 cycles after acceptance, busy high throughout.
REQ-030 SHALL cover: signed 0xFFFFFFF9/2 (-7/2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; unsigned same operands -> quotient=0x7FFFFFFC, remainder=1.
REQ-031 SHALL cover: signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0; 0x12345678/0 -> quotient=0xFFFFFFFF, remainder=0x12345678.
REQ-032 SHALL cover: res_ready held low 5 cycles after res_valid -> outputs unchanged and div_ready=0; res_ready=1 -> IDLE next cycle; back-to-back request accepted the cycle after.
REQ-033 SHALL cover: flush at CALC counter=10 with div_valid=1 -> IDLE next cycle, no acceptance, no res_valid; then a fresh 9/3 -> quotient=3, remainder=0.
REQ-034 SHALL cover: reset asserted at CALC counter=20 -> all outputs 0, div_ready=1 next cycle, no stale res_valid afterwards.
